uart_tx_answer: RTL and testbench

UART transmitter returning answer bytes to the host over the same serial link whose receive side loads the VGA frame RAM. It accepts bytes through a valid/ready handshake into an internal FIFO and serialises them LSB-first with start bit, optional parity and one or two stop bits. The frame format is selectable so it matches the receiver: 8 data bits, parity on, 2 stop bits, 115200 baud. It sits in the `clk_sys` domain next to `UART_Controller` and drives the board `tx` pin.

---
 rtl/uart_tx_answer.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_answer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_answer.sv
// uart_tx_answer: FIFO-buffered UART transmitter returning answer bytes.
// Ports: clk, rst, data_in/valid/ready push side, txd, busy, tx_done, fifo_level.
module uart_tx_answer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          valid,
  output logic                          ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic PODD = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t         state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic           stop_cnt;
  logic [7:0]     shift;
  logic           par;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [7:0]     head;

  logic bit_end;
  logic last_stop;
  logic frame_end;
  logic push;
  logic pop;

  assign head      = mem[rd_ptr];
  assign ready     = (fifo_level != FULL);
  assign push      = valid && ready;
  assign bit_end   = (baud_cnt == CW'(DIV - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign frame_end = (state == S_STOP) && bit_end && last_stop;
  // Pop from idle, or at the end of a frame so frames run back to back.
  assign pop = (fifo_level != '0) &&
               ((state == S_IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par      <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      // Registered, so raise it one cycle ahead of the final stop cycle.
      tx_done <= (state == S_STOP) && last_stop &&
                 (baud_cnt == CW'(DIV - 2));
      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + CW'(1);
      if (pop) begin
        shift <= head;
        par   <= (^head) ^ PODD;
      end
      case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            state <= S_START;
            txd   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            txd     <= shift[0];
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                state <= S_PAR;
                txd   <= par;
              end else begin
                state    <= S_STOP;
                txd      <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        S_PAR: begin
          if (bit_end) begin
            state    <= S_STOP;
            txd      <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              stop_cnt <= 1'b1;
            end else if (pop) begin
              state <= S_START;
              txd   <= 1'b0;
            end else begin
              state <= S_IDLE;
              txd   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_answer.sv
// tb_uart_tx_answer: scoreboard bench for uart_tx_answer.
// Three instances: DIV=8 even/2-stop, DIV=8 odd/1-stop, DIV=434.
module tb_uart_tx_answer;

  logic       clk;
  logic       rst;
  logic       valid_w [3];
  logic [7:0] din_w   [3];
  logic       ready_w [3];
  logic       txd_w   [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic [4:0] lvl_w   [3];
  logic       abort   [3];

  int checks = 0;
  int errors = 0;

  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [11:0] q2[$];

  int run      [3];
  int last_run [3];

  logic       saw_full;
  logic [4:0] full_lvl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_answer #(
    .CLK_HZ(8), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(0),
    .STOP_BITS(2), .FIFO_DEPTH(16)
  ) u0 (
    .clk(clk), .rst(rst), .data_in(din_w[0]), .valid(valid_w[0]),
    .ready(ready_w[0]), .txd(txd_w[0]), .busy(busy_w[0]),
    .tx_done(done_w[0]), .fifo_level(lvl_w[0])
  );

  uart_tx_answer #(
    .CLK_HZ(8), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(1),
    .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u1 (
    .clk(clk), .rst(rst), .data_in(din_w[1]), .valid(valid_w[1]),
    .ready(ready_w[1]), .txd(txd_w[1]), .busy(busy_w[1]),
    .tx_done(done_w[1]), .fifo_level(lvl_w[1])
  );

  uart_tx_answer #(
    .CLK_HZ(50_000_000), .BAUD(115200), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) u2 (
    .clk(clk), .rst(rst), .data_in(din_w[2]), .valid(valid_w[2]),
    .ready(ready_w[2]), .txd(txd_w[2]), .busy(busy_w[2]),
    .tx_done(done_w[2]), .fifo_level(lvl_w[2])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pushq(input int k, input logic [11:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic popq(input int k, output logic [11:0] v);
    case (k)
      0:       v = q0.pop_front();
      1:       v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  task automatic clrq(input int k);
    case (k)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Busy run-length tracker per instance.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (busy_w[k] === 1'b1) begin
        run[k] <= run[k] + 1;
      end else begin
        if (run[k] != 0) last_run[k] <= run[k];
        run[k] <= 0;
      end
    end
  end

  // Serial monitor: every cycle of every bit must match the expected frame.
  task automatic monitor(input int k, input int div, input int nb);
    logic [11:0] e;
    logic        got;
    logic        early;
    logic        last_done;
    logic        busy_low;
    bit          ab;
    int          n;
    forever begin
      @(negedge clk);
      if (abort[k]) begin
        clrq(k);
        continue;
      end
      if (txd_w[k] !== 1'b0) continue;
      if (qsize(k) == 0) begin
        chk($sformatf("u%0d unexpected start", k),
            32'(txd_w[k]), 32'd1);
        n = 0;
        while (txd_w[k] !== 1'b1 && n < 20000) begin
          @(negedge clk);
          n++;
        end
        continue;
      end
      popq(k, e);
      ab = 1'b0;
      early = 1'b0;
      last_done = 1'b0;
      busy_low = 1'b0;
      for (int b = 0; b < nb && !ab; b++) begin
        got = e[b];
        for (int c = 0; c < div; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (abort[k]) begin
            ab = 1'b1;
            break;
          end
          if (txd_w[k] !== e[b]) got = txd_w[k];
          if (busy_w[k] !== 1'b1) busy_low = 1'b1;
          if (b == nb - 1 && c == div - 1) last_done = done_w[k];
          else if (done_w[k] !== 1'b0) early = 1'b1;
        end
        if (!ab)
          chk($sformatf("u%0d bit%0d", k, b), 32'(got), 32'(e[b]));
      end
      if (ab) begin
        clrq(k);
        continue;
      end
      chk($sformatf("u%0d tx_done last", k), 32'(last_done), 32'd1);
      chk($sformatf("u%0d tx_done early", k), 32'(early), 32'd0);
      chk($sformatf("u%0d busy in frame", k), 32'(busy_low), 32'd0);
    end
  endtask

  initial monitor(0, 8, 12);
  initial monitor(1, 8, 11);
  initial monitor(2, 434, 12);

  task automatic push(input int k, input logic [7:0] b, input logic p);
    int n;
    @(negedge clk);
    valid_w[k] = 1'b1;
    din_w[k] = b;
    n = 0;
    while (ready_w[k] !== 1'b1 && n < 2000) begin
      if (!saw_full) begin
        saw_full = 1'b1;
        full_lvl = lvl_w[k];
      end
      @(negedge clk);
      n++;
    end
    if (n >= 2000)
      chk($sformatf("u%0d ready timeout", k), 32'(ready_w[k]), 32'd1);
    pushq(k, {2'b11, p, b, 1'b0});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int k);
    int n;
    n = 0;
    while ((qsize(k) != 0 || busy_w[k] !== 1'b0 || lvl_w[k] != 0) &&
           n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000)
      chk($sformatf("u%0d drain timeout", k), 32'(busy_w[k]), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] fill [18];
  int lowc;

  initial begin
    fill = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87,
             8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'h0F,
             8'h81, 8'h7E};
    rst = 1'b1;
    saw_full = 1'b0;
    full_lvl = '0;
    for (int k = 0; k < 3; k++) begin
      valid_w[k] = 1'b0;
      din_w[k] = '0;
      abort[k] = 1'b0;
      run[k] = 0;
      last_run[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset txd", 32'(txd_w[0]), 32'd1);
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset tx_done", 32'(done_w[0]), 32'd0);
    chk("reset level", 32'(lvl_w[0]), 32'd0);
    chk("reset ready", 32'(ready_w[0]), 32'd1);
    rst = 1'b0;

    push(0, 8'hA5, 1'b0);
    valid_w[0] = 1'b0;
    @(negedge clk);
    chk("accept level", 32'(lvl_w[0]), 32'd1);
    chk("accept txd", 32'(txd_w[0]), 32'd1);
    chk("accept busy", 32'(busy_w[0]), 32'd0);
    @(negedge clk);
    chk("pop level", 32'(lvl_w[0]), 32'd0);
    chk("pop txd", 32'(txd_w[0]), 32'd0);
    chk("pop busy", 32'(busy_w[0]), 32'd1);
    wait_drain(0);
    chk("single busy run", 32'(last_run[0]), 32'd96);
    chk("single idle txd", 32'(txd_w[0]), 32'd1);

    push(0, 8'h00, 1'b0);
    push(0, 8'hFF, 1'b0);
    push(0, 8'h55, 1'b0);
    valid_w[0] = 1'b0;
    wait_drain(0);
    chk("b2b busy run", 32'(last_run[0]), 32'd288);

    saw_full = 1'b0;
    for (int i = 0; i < 18; i++) push(0, fill[i], ^fill[i]);
    valid_w[0] = 1'b0;
    wait_drain(0);
    chk("full seen", 32'(saw_full), 32'd1);
    chk("full level", 32'(full_lvl), 32'd16);
    chk("full busy run", 32'(last_run[0]), 32'd1728);

    saw_full = 1'b1;
    push(0, 8'h3C, 1'b0);
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b0);
    valid_w[0] = 1'b0;
    repeat (40) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    chk("pre-reset level", 32'(lvl_w[0]), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset txd", 32'(txd_w[0]), 32'd1);
    chk("mid reset busy", 32'(busy_w[0]), 32'd0);
    chk("mid reset level", 32'(lvl_w[0]), 32'd0);
    chk("mid reset ready", 32'(ready_w[0]), 32'd1);
    chk("mid reset tx_done", 32'(done_w[0]), 32'd0);
    lowc = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) lowc++;
    end
    chk("post reset quiet", 32'(lowc), 32'd0);
    abort[0] = 1'b0;

    push(1, 8'h01, 1'b0);
    valid_w[1] = 1'b0;
    wait_drain(1);
    chk("odd 1stop busy run", 32'(last_run[1]), 32'd88);

    push(2, 8'h5A, 1'b0);
    valid_w[2] = 1'b0;
    wait_drain(2);
    chk("div434 busy run", 32'(last_run[2]), 32'd5208);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
